// File: rtl/counter_mod_n_pkg.sv
// Shared defaults and parameter-legality check
// for the modulo-N counter.
package counter_mod_n_pkg;

  localparam int N_DEF  = 10;
  localparam int B_DEF  = 4;
  localparam int WW_DEF = 8;

  // 2**b must hold every count 0..N-1
  function automatic bit params_ok(
    input int n,
    input int bw,
    input int ww
  );
    if (n < 2 || ww < 1) return 1'b0;
    if (bw < 1 || bw > 30) return 1'b0;
    return (1 << bw) >= n;
  endfunction

endpackage

// File: rtl/counter_mod_n_bin2gray.sv
// Combinational binary to reflected-Gray
// conversion.
module bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/counter_mod_n.sv
// Free-running modulo-N counter with terminal
// count, Gray view and wrap-event counter.
module counter_mod_n
  import counter_mod_n_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int b  = B_DEF,
  parameter int WW = WW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  output logic [b-1:0]  out,
  output logic          tc,
  output logic [b-1:0]  out_gray,
  output logic [WW-1:0] wraps
);

  if (!params_ok(N, b, WW)) begin : g_param_err
    $error("counter_mod_n: illegal N/b/WW");
  end

  localparam logic [b-1:0] LAST = b'(N - 1);

  logic [b-1:0]  out_q;
  logic [b-1:0]  out_d;
  logic [WW-1:0] wraps_q;
  logic [WW-1:0] wraps_d;

  // out_q > LAST only after an upset
  always_comb begin
    out_d   = out_q;
    wraps_d = wraps_q;
    unique case (1'b1)
      (out_q < LAST): begin
        out_d = out_q + b'(1);
      end
      (out_q == LAST): begin
        out_d   = '0;
        wraps_d = wraps_q + WW'(1);
      end
      default: begin
        out_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      wraps_q <= '0;
    end else begin
      out_q   <= out_d;
      wraps_q <= wraps_d;
    end
  end

  assign out   = out_q;
  assign wraps = wraps_q;
  assign tc    = (out_q == LAST);

  bin2gray #(
    .WIDTH(b)
  ) u_gray (
    .bin  (out_q),
    .gray (out_gray)
  );

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed bench for counter_mod_n with
// default N=10, b=4, WW=8.
module tb_counter_mod_n;

  logic       clk;
  logic       reset;
  logic [3:0] out;
  logic       tc;
  logic [3:0] out_gray;
  logic [7:0] wraps;

  int n_vec;
  int n_bad;

  // hand-computed Gray codes for 0..9
  int gray_tab [10] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13};

  counter_mod_n dut (
    .clk      (clk),
    .reset    (reset),
    .out      (out),
    .tc       (tc),
    .out_gray (out_gray),
    .wraps    (wraps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input int    got,
    input int    exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic check_all(
    input string tag,
    input int    e_out,
    input int    e_wraps
  );
    check({tag, ".out"}, int'(out), e_out);
    check({tag, ".tc"}, int'(tc),
          (e_out == 9) ? 1 : 0);
    check({tag, ".gray"}, int'(out_gray),
          gray_tab[e_out]);
    check({tag, ".wraps"}, int'(wraps), e_wraps);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;

    #2;
    check_all("rst_async", 0, 0);

    @(posedge clk);
    #2;
    check_all("rst_hold", 0, 0);

    #5;
    reset = 1'b1;
    #1;
    check_all("rel_pre_edge", 0, 0);

    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("seq%0d", i),
                i % 10, (i == 10) ? 1 : 0);
    end

    repeat (5) @(posedge clk);
    #1;
    check_all("at5", 5, 1);

    #2;
    reset = 1'b0;
    #1;
    check_all("mid_rst", 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check_all("mid_rst_hold", 0, 0);

    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("rel2_first", 1, 0);

    // 9 + 255*10 edges to just before rollover
    repeat (2558) @(posedge clk);
    #1;
    check_all("pre_roll", 9, 255);

    @(posedge clk);
    #1;
    check_all("roll", 0, 0);

    repeat (10) @(posedge clk);
    #1;
    check_all("wrap1", 0, 1);

    repeat (3) @(posedge clk);
    #1;
    check_all("at3", 3, 1);

    @(negedge clk);
    force dut.out_q = 4'd12;
    #1;
    check("ill12.out", int'(out), 12);
    check("ill12.tc", int'(tc), 0);
    check("ill12.gray", int'(out_gray), 10);
    release dut.out_q;
    @(posedge clk);
    #1;
    check_all("ill12_next", 0, 1);

    @(negedge clk);
    force dut.out_q = 4'd15;
    #1;
    check("ill15.gray", int'(out_gray), 8);
    release dut.out_q;
    @(posedge clk);
    #1;
    check_all("ill15_next", 0, 1);

    @(posedge clk);
    #1;
    check_all("after_ill", 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
